// File: rtl/ether_rx_frame_parser.sv
// Receive frame parser: validates preamble/SFD on the 2-bit core-clock stream and emits payload dibits with framing.
// Define ETHER_RX_FRAME_PARSER_CRC_EN to add the CRC-32 check, FCS stripping and the 16-deep delay line.
module ether_rx_frame_parser #(
  parameter int DATA_BITS    = 2,
  parameter int MIN_PREAMBLE = 15,
  parameter int COUNTER_BITS = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_rx_last,
  input  logic [DATA_BITS-1:0]    s_rx_data,
  input  logic                    s_rx_valid,
  output logic                    m_first,
  output logic                    m_last,
  output logic [DATA_BITS-1:0]    m_data,
  output logic                    m_valid,
  output logic                    m_stat_valid,
  output logic                    m_stat_pre_err,
  output logic                    m_stat_runt,
  output logic                    m_stat_crc_err,
  output logic [COUNTER_BITS-1:0] frame_ok_count,
  output logic [COUNTER_BITS-1:0] frame_err_count
);

  localparam int PRE_W = $clog2(MIN_PREAMBLE + 1);
  localparam logic [PRE_W-1:0] PRE_MIN = PRE_W'(MIN_PREAMBLE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  state_t                  state_reg, state_next;
  logic [PRE_W-1:0]        pre_cnt_reg, pre_cnt_next;
  logic                    pre_err_reg, pre_err_next;
  logic                    runt_reg, runt_next;
  logic                    first_reg, first_next;

  logic                    push;
  logic                    end_frame;
  logic                    pre_err_acc;
  logic                    runt_acc;
  logic                    runt_final;
  logic                    crc_err_final;
  logic                    out_valid;
  logic [DATA_BITS-1:0]    out_data;

  logic                    m_first_reg, m_last_reg, m_valid_reg;
  logic [DATA_BITS-1:0]    m_data_reg;
  logic                    m_stat_valid_reg, m_stat_pre_err_reg, m_stat_runt_reg, m_stat_crc_err_reg;
  logic [COUNTER_BITS-1:0] frame_ok_count_reg, frame_err_count_reg;

`ifdef ETHER_RX_FRAME_PARSER_CRC_EN
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam int          DL_DEPTH    = 16;

  logic [31:0]             crc_reg, crc_next, crc_upd;
  logic [2*DL_DEPTH-1:0]   dl_reg, dl_next;
  logic [4:0]              dl_cnt_reg, dl_cnt_next;
  logic                    emit;

  // Reflected CRC-32, line bit0 of the dibit enters first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] crc_in, input logic [1:0] dibit);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ dibit[i]) c = (c >> 1) ^ CRC_POLY;
      else                 c = c >> 1;
    end
    return c;
  endfunction
`endif

  always_comb begin
    state_next   = state_reg;
    pre_cnt_next = pre_cnt_reg;
    pre_err_acc  = pre_err_reg;
    runt_acc     = runt_reg;
    first_next   = first_reg;
    push         = 1'b0;
    end_frame    = s_rx_valid && s_rx_last;

    if (s_rx_valid) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (s_rx_data == 2'b01) begin
            pre_cnt_next = PRE_W'(1);
            state_next   = ST_PREAMBLE;
          end else begin
            pre_err_acc = 1'b1;
            state_next  = ST_DROP;
          end
        end
        ST_PREAMBLE: begin
          if (s_rx_data == 2'b01) begin
            if (pre_cnt_reg < PRE_MIN) pre_cnt_next = pre_cnt_reg + 1'b1;
          end else if (s_rx_data == 2'b11 && pre_cnt_reg >= PRE_MIN) begin
            state_next = ST_PAYLOAD;
            first_next = 1'b1;
          end else begin
            pre_err_acc = 1'b1;
            state_next  = ST_DROP;
          end
        end
        ST_PAYLOAD: push = 1'b1;
        default: ;
      endcase
      // Ending before any payload beat (SFD beat included) is a truncated preamble.
      if (s_rx_last && (state_reg == ST_IDLE || state_reg == ST_PREAMBLE)) begin
        pre_err_acc = 1'b1;
        runt_acc    = 1'b1;
      end
    end

`ifdef ETHER_RX_FRAME_PARSER_CRC_EN
    crc_next    = crc_reg;
    crc_upd     = crc_reg;
    dl_next     = dl_reg;
    dl_cnt_next = dl_cnt_reg;
    emit        = push && (dl_cnt_reg == 5'(DL_DEPTH));
    out_valid   = emit;
    out_data    = dl_reg[2*DL_DEPTH-1 -: 2];
    if (push) begin
      crc_upd  = crc_dibit(crc_reg, s_rx_data);
      crc_next = crc_upd;
      dl_next  = {dl_reg[2*DL_DEPTH-3:0], s_rx_data};
      if (!emit) dl_cnt_next = dl_cnt_reg + 5'd1;
    end
    runt_final    = runt_acc | (end_frame && push && !emit);
    crc_err_final = end_frame && push && !pre_err_acc && !runt_final && (crc_upd != CRC_RESIDUE);
    if (end_frame) begin
      crc_next    = CRC_INIT;
      dl_cnt_next = 5'd0;
    end
`else
    out_valid     = push;
    out_data      = s_rx_data;
    runt_final    = runt_acc;
    crc_err_final = 1'b0;
`endif

    if (out_valid) first_next = 1'b0;
    pre_err_next = end_frame ? 1'b0 : pre_err_acc;
    runt_next    = end_frame ? 1'b0 : runt_acc;
    if (end_frame) begin
      state_next = ST_IDLE;
      first_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= ST_IDLE;
      pre_cnt_reg        <= '0;
      pre_err_reg        <= 1'b0;
      runt_reg           <= 1'b0;
      first_reg          <= 1'b0;
      m_first_reg        <= 1'b0;
      m_last_reg         <= 1'b0;
      m_valid_reg        <= 1'b0;
      m_data_reg         <= '0;
      m_stat_valid_reg   <= 1'b0;
      m_stat_pre_err_reg <= 1'b0;
      m_stat_runt_reg    <= 1'b0;
      m_stat_crc_err_reg <= 1'b0;
    end else begin
      state_reg          <= state_next;
      pre_cnt_reg        <= pre_cnt_next;
      pre_err_reg        <= pre_err_next;
      runt_reg           <= runt_next;
      first_reg          <= first_next;
      m_valid_reg        <= out_valid;
      m_data_reg         <= out_valid ? out_data : '0;
      m_first_reg        <= out_valid & first_reg;
      m_last_reg         <= out_valid & s_rx_last;
      m_stat_valid_reg   <= end_frame;
      m_stat_pre_err_reg <= end_frame & pre_err_acc;
      m_stat_runt_reg    <= end_frame & runt_final;
      m_stat_crc_err_reg <= crc_err_final;
    end
  end

`ifdef ETHER_RX_FRAME_PARSER_CRC_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_reg    <= CRC_INIT;
      dl_reg     <= '0;
      dl_cnt_reg <= 5'd0;
    end else begin
      crc_reg    <= crc_next;
      dl_reg     <= dl_next;
      dl_cnt_reg <= dl_cnt_next;
    end
  end
`endif

  // Statistics lag the stat pulse by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_ok_count_reg  <= '0;
      frame_err_count_reg <= '0;
    end else if (m_stat_valid_reg) begin
      if (m_stat_pre_err_reg || m_stat_runt_reg || m_stat_crc_err_reg) begin
        if (frame_err_count_reg != '1) frame_err_count_reg <= frame_err_count_reg + 1'b1;
      end else begin
        if (frame_ok_count_reg != '1) frame_ok_count_reg <= frame_ok_count_reg + 1'b1;
      end
    end
  end

  assign m_first         = m_first_reg;
  assign m_last          = m_last_reg;
  assign m_data          = m_data_reg;
  assign m_valid         = m_valid_reg;
  assign m_stat_valid    = m_stat_valid_reg;
  assign m_stat_pre_err  = m_stat_pre_err_reg;
  assign m_stat_runt     = m_stat_runt_reg;
  assign m_stat_crc_err  = m_stat_crc_err_reg;
  assign frame_ok_count  = frame_ok_count_reg;
  assign frame_err_count = frame_err_count_reg;

endmodule

// File: tb/tb_ether_rx_frame_parser.sv
// Directed table-driven bench for ether_rx_frame_parser; each table row is one clock of input and the outputs it produces.
module tb_ether_rx_frame_parser;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_rx_last = 1'b0;
  logic [1:0]  s_rx_data = 2'b00;
  logic        s_rx_valid = 1'b0;
  logic        m_first, m_last, m_valid;
  logic [1:0]  m_data;
  logic        m_stat_valid, m_stat_pre_err, m_stat_runt, m_stat_crc_err;
  logic [15:0] frame_ok_count, frame_err_count;

  ether_rx_frame_parser #(
    .DATA_BITS(2),
    .MIN_PREAMBLE(15),
    .COUNTER_BITS(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .s_rx_last(s_rx_last),
    .s_rx_data(s_rx_data),
    .s_rx_valid(s_rx_valid),
    .m_first(m_first),
    .m_last(m_last),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_stat_valid(m_stat_valid),
    .m_stat_pre_err(m_stat_pre_err),
    .m_stat_runt(m_stat_runt),
    .m_stat_crc_err(m_stat_crc_err),
    .frame_ok_count(frame_ok_count),
    .frame_err_count(frame_err_count)
  );

  always #5 clk = ~clk;

  // exp = {m_valid, m_first, m_last, m_data[1:0], m_stat_valid, pre_err, runt, crc_err}
  typedef struct {
    logic       v;
    logic       l;
    logic [1:0] d;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;
  int   exp_ok = 0;
  int   exp_err = 0;

  function automatic logic [8:0] e(input logic mv, input logic mf, input logic ml, input logic [1:0] md,
                                   input logic sv, input logic pe, input logic ru, input logic ce);
    return {mv, mf, ml, md, sv, pe, ru, ce};
  endfunction

  function automatic logic [8:0] outs();
    return {m_valid, m_first, m_last, m_data, m_stat_valid, m_stat_pre_err, m_stat_runt, m_stat_crc_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add_beat(input logic l, input logic [1:0] d, input logic [8:0] exp, input logic gap);
    vecs.push_back('{1'b1, l, d, exp});
    if (gap) vecs.push_back('{1'b0, 1'b0, 2'b00, 9'd0});
  endtask

  task automatic add_pre(input int n, input logic gap);
    for (int i = 0; i < n; i++) add_beat(1'b0, 2'b01, 9'd0, gap);
  endtask

  // Clean frame: npre preamble dibits, SFD, payload.
  task automatic add_good_frame(input int npre, input logic gap, input logic flip);
    add_pre(npre, gap);
    add_beat(1'b0, 2'b11, 9'd0, gap);
`ifdef ETHER_RX_FRAME_PARSER_CRC_EN
    begin
      // 0x00 then FCS 8D EF 02 D2, LSB dibit first
      logic [1:0] p [20];
      p = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11, 2'b11,
            2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11};
      if (flip) p[19] = 2'b01;
      for (int i = 0; i < 20; i++) begin
        if (i < 16) add_beat(1'b0, p[i], 9'd0, gap);
        else add_beat(i == 19, p[i], e(1'b1, i == 16, i == 19, 2'b00, i == 19, 1'b0, 1'b0, flip && i == 19), gap);
      end
    end
`else
    add_beat(1'b0, 2'b00, e(1, 1, 0, 2'b00, 0, 0, 0, 0), gap);
    add_beat(1'b0, 2'b01, e(1, 0, 0, 2'b01, 0, 0, 0, 0), gap);
    add_beat(1'b0, 2'b10, e(1, 0, 0, 2'b10, 0, 0, 0, 0), gap);
    add_beat(1'b1, 2'b11, e(1, 0, 1, 2'b11, 1, 0, 0, flip), gap);
`endif
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      s_rx_valid = vecs[i].v;
      s_rx_last  = vecs[i].l;
      s_rx_data  = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("%s_row%0d", tag, i), 32'(outs()), 32'(vecs[i].exp));
    end
    s_rx_valid = 1'b0;
    s_rx_last  = 1'b0;
    s_rx_data  = 2'b00;
    vecs.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'(outs()), 32'd0);
    check("reset_counts", {frame_ok_count, frame_err_count}, 32'd0);
    reset_n = 1'b1;

    add_good_frame(15, 1'b0, 1'b0);                      exp_ok++;
    add_good_frame(15, 1'b1, 1'b0);                      exp_ok++;
    // short preamble: 10 x 01, SFD, 8 dibits
    add_pre(10, 1'b0);
    add_beat(1'b0, 2'b11, 9'd0, 1'b0);
    for (int i = 0; i < 7; i++) add_beat(1'b0, 2'b10, 9'd0, 1'b0);
    add_beat(1'b1, 2'b10, e(0, 0, 0, 2'b00, 1, 1, 0, 0), 1'b0); exp_err++;
    // 00 inside the preamble
    add_pre(5, 1'b0);
    add_beat(1'b0, 2'b00, 9'd0, 1'b0);
    add_pre(9, 1'b0);
    add_beat(1'b0, 2'b11, 9'd0, 1'b0);
    for (int i = 0; i < 7; i++) add_beat(1'b0, 2'b01, 9'd0, 1'b0);
    add_beat(1'b1, 2'b01, e(0, 0, 0, 2'b00, 1, 1, 0, 0), 1'b0); exp_err++;
    // one dibit short of the minimum preamble
    add_pre(14, 1'b0);
    add_beat(1'b0, 2'b11, 9'd0, 1'b0);
    add_beat(1'b0, 2'b00, 9'd0, 1'b0);
    add_beat(1'b1, 2'b00, e(0, 0, 0, 2'b00, 1, 1, 0, 0), 1'b0); exp_err++;
    add_good_frame(20, 1'b0, 1'b0);                      exp_ok++;
    // last in IDLE, on the SFD, inside the preamble
    add_beat(1'b1, 2'b01, e(0, 0, 0, 2'b00, 1, 1, 1, 0), 1'b0); exp_err++;
    add_pre(15, 1'b0);
    add_beat(1'b1, 2'b11, e(0, 0, 0, 2'b00, 1, 1, 1, 0), 1'b0); exp_err++;
    add_pre(2, 1'b0);
    add_beat(1'b1, 2'b01, e(0, 0, 0, 2'b00, 1, 1, 1, 0), 1'b0); exp_err++;
    // first dibit is not preamble
    add_beat(1'b0, 2'b11, 9'd0, 1'b0);
    add_beat(1'b0, 2'b01, 9'd0, 1'b0);
    add_beat(1'b1, 2'b00, e(0, 0, 0, 2'b00, 1, 1, 0, 0), 1'b0); exp_err++;
    // single payload dibit
    add_pre(15, 1'b0);
    add_beat(1'b0, 2'b11, 9'd0, 1'b0);
`ifdef ETHER_RX_FRAME_PARSER_CRC_EN
    add_beat(1'b1, 2'b10, e(0, 0, 0, 2'b00, 1, 0, 1, 0), 1'b0); exp_err++;
    // exactly 16 payload dibits is still a runt
    add_pre(15, 1'b0);
    add_beat(1'b0, 2'b11, 9'd0, 1'b0);
    for (int i = 0; i < 15; i++) add_beat(1'b0, 2'b10, 9'd0, 1'b0);
    add_beat(1'b1, 2'b10, e(0, 0, 0, 2'b00, 1, 0, 1, 0), 1'b0); exp_err++;
    add_good_frame(15, 1'b0, 1'b1);                      exp_err++;
`else
    add_beat(1'b1, 2'b10, e(1, 1, 1, 2'b10, 1, 0, 0, 0), 1'b0); exp_ok++;
`endif
    run_table("main");
    @(posedge clk);
    #1;
    check("main_ok_count", 32'(frame_ok_count), 32'(exp_ok));
    check("main_err_count", 32'(frame_err_count), 32'(exp_err));

    // reset pulsed mid-payload
    add_pre(15, 1'b0);
    add_beat(1'b0, 2'b11, 9'd0, 1'b0);
`ifdef ETHER_RX_FRAME_PARSER_CRC_EN
    add_beat(1'b0, 2'b00, 9'd0, 1'b0);
    add_beat(1'b0, 2'b01, 9'd0, 1'b0);
`else
    add_beat(1'b0, 2'b00, e(1, 1, 0, 2'b00, 0, 0, 0, 0), 1'b0);
    add_beat(1'b0, 2'b01, e(1, 0, 0, 2'b01, 0, 0, 0, 0), 1'b0);
`endif
    run_table("prereset");
    reset_n = 1'b0;
    #1;
    check("async_reset_outs", 32'(outs()), 32'd0);
    check("async_reset_counts", {frame_ok_count, frame_err_count}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    add_beat(1'b0, 2'b10, 9'd0, 1'b0);
    add_beat(1'b1, 2'b11, e(0, 0, 0, 2'b00, 1, 1, 0, 0), 1'b0);
    add_good_frame(15, 1'b0, 1'b0);
    run_table("postreset");
    @(posedge clk);
    #1;
    check("post_ok_count", 32'(frame_ok_count), 32'd1);
    check("post_err_count", 32'(frame_err_count), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
